// File: rtl/phy_rx_serial.sv
// Receive-side serial-to-parallel converter: finds byte alignment on the idle
// comma, declares the link active after SYNC_COUNT aligned commas, then emits lane-tagged bytes.
module phy_rx_serial #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic       active,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic [1:0] lane_out
);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_ALIGN,
    ST_ACTIVE
  } state_t;

  localparam logic [3:0] SYNC_TARGET = 4'(SYNC_COUNT);

  state_t     state, state_nxt;
  logic [7:0] sr;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [3:0] bc_cnt, bc_cnt_nxt;
  logic [1:0] lane_cnt, lane_cnt_nxt;
  logic [7:0] data_nxt;
  logic       valid_nxt;
  logic       strobe_nxt;
  logic [1:0] lane_out_nxt;
  logic       is_comma;
  logic       boundary;

  // Compare only the registered shift register, never data_in directly.
  assign is_comma = (sr == COMMA);
  assign boundary = (bit_cnt == 3'd0) && (state != ST_SEARCH);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt    = state;
    bit_cnt_nxt  = 3'(bit_cnt + 3'd1);
    bc_cnt_nxt   = bc_cnt;
    lane_cnt_nxt = lane_cnt;
    data_nxt     = data_out;
    valid_nxt    = valid_out;
    strobe_nxt   = 1'b0;
    lane_out_nxt = lane_out;

    unique case (state)
      ST_SEARCH: begin
        bit_cnt_nxt = 3'd0;
        if (is_comma) begin
          // The matching cycle is boundary 0 of the new framing.
          state_nxt   = ST_ALIGN;
          bc_cnt_nxt  = 4'd1;
          bit_cnt_nxt = 3'd1;
        end
      end

      ST_ALIGN: begin
        if (boundary) begin
          if (is_comma) begin
            bc_cnt_nxt = 4'(bc_cnt + 4'd1);
            if (4'(bc_cnt + 4'd1) == SYNC_TARGET) begin
              state_nxt    = ST_ACTIVE;
              lane_cnt_nxt = 2'd0;
            end
          end else begin
            state_nxt   = ST_SEARCH;
            bc_cnt_nxt  = 4'd0;
            bit_cnt_nxt = 3'd0;
          end
        end
      end

      ST_ACTIVE: begin
        // Sticky: framing is trusted once synchronized, bc_cnt stays saturated.
        if (boundary) begin
          data_nxt     = sr;
          valid_nxt    = !is_comma;
          strobe_nxt   = 1'b1;
          lane_out_nxt = lane_cnt;
          lane_cnt_nxt = 2'(lane_cnt + 2'd1);
        end
      end

      default: begin
        state_nxt = ST_SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state       <= ST_SEARCH;
      sr          <= 8'h00;
      bit_cnt     <= 3'd0;
      bc_cnt      <= 4'd0;
      lane_cnt    <= 2'd0;
      active      <= 1'b0;
      data_out    <= 8'h00;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
      lane_out    <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state       <= state_nxt;
      sr          <= {sr[6:0], data_in};
      bit_cnt     <= bit_cnt_nxt;
      bc_cnt      <= bc_cnt_nxt;
      lane_cnt    <= lane_cnt_nxt;
      active      <= (state_nxt == ST_ACTIVE);
      data_out    <= data_nxt;
      valid_out   <= valid_nxt;
      byte_strobe <= strobe_nxt;
      lane_out    <= lane_out_nxt;
    end
  end

endmodule

// File: tb/tb_phy_rx_serial.sv
// Bench for phy_rx_serial: directed and random bit streams, checked per cycle
// against a window-scan model of the alignment and output rules.
module tb_phy_rx_serial;

  localparam logic [7:0] COMMA      = 8'hBC;
  localparam int         SYNC_COUNT = 4;

  logic       clk_32f;
  logic       reset;
  logic       data_in;
  logic       active;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic [1:0] lane_out;

  int n_compared   = 0;
  int n_mismatched = 0;

  bit       stream[$];
  bit       e_act[$];
  bit       e_strb[$];
  bit       e_valid[$];
  bit [7:0] e_data[$];
  bit [1:0] e_lane[$];

  phy_rx_serial #(.COMMA(COMMA), .SYNC_COUNT(SYNC_COUNT)) dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .active     (active),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .byte_strobe(byte_strobe),
    .lane_out   (lane_out)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic push_byte(input bit [7:0] b);
    for (int i = 7; i >= 0; i--) stream.push_back(b[i]);
  endtask

  task automatic push_rand_bits(input int n);
    for (int i = 0; i < n; i++) stream.push_back(1'($urandom));
  endtask

  // Byte formed by the eight bits ending at index k, oldest bit in the MSB.
  function automatic bit [7:0] win(input int k);
    bit [7:0] w = 8'h00;
    for (int i = 0; i < 8; i++)
      if (k - 7 + i >= 0) w[7 - i] = stream[k - 7 + i];
    return w;
  endfunction

  // Expected outputs after clock edge e (edge e samples stream[e]).
  task automatic build_model();
    int n = stream.size();
    int a = -1;
    int k = 0;
    e_act.delete(); e_strb.delete(); e_valid.delete(); e_data.delete(); e_lane.delete();
    for (int e = 0; e < n; e++) begin
      e_act.push_back(1'b0); e_strb.push_back(1'b0); e_valid.push_back(1'b0);
      e_data.push_back(8'h00); e_lane.push_back(2'd0);
    end
    while (k < n && a < 0) begin
      if (win(k) == COMMA) begin
        int run = 1;
        int pos = k;
        while (run < SYNC_COUNT && pos + 8 < n && win(pos + 8) == COMMA) begin
          pos += 8;
          run++;
        end
        if (run == SYNC_COUNT) a = pos;
        else if (pos + 8 < n) k = pos + 9;
        else k = n;
      end else begin
        k++;
      end
    end
    if (a >= 0) begin
      for (int e = a + 1; e < n; e++) e_act[e] = 1'b1;
      for (int m = 1; a + 8 * m + 1 < n; m++) begin
        int ed = a + 8 * m + 1;
        e_strb[ed]  = 1'b1;
        e_data[ed]  = win(a + 8 * m);
        e_valid[ed] = (win(a + 8 * m) != COMMA);
        e_lane[ed]  = 2'((m - 1) % 4);
      end
    end
    for (int e = 1; e < n; e++) begin
      if (!e_strb[e]) begin
        e_data[e]  = e_data[e - 1];
        e_valid[e] = e_valid[e - 1];
        e_lane[e]  = e_lane[e - 1];
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_active"}, 32'(active), 32'd0);
    check({tag, "_data"},   32'(data_out), 32'd0);
    check({tag, "_valid"},  32'(valid_out), 32'd0);
    check({tag, "_strobe"}, 32'(byte_strobe), 32'd0);
    check({tag, "_lane"},   32'(lane_out), 32'd0);
  endtask

  // Asynchronous reset between edges, 5 reset cycles, then play the stream.
  task automatic run_segment();
    build_model();
    #1 reset = 1'b0;
    #1 check_reset_outputs("rst_async");
    repeat (5) begin
      @(negedge clk_32f);
      data_in = 1'($urandom);
      @(posedge clk_32f);
      #1 check_reset_outputs("rst_hold");
    end
    for (int e = 0; e < stream.size(); e++) begin
      @(negedge clk_32f);
      if (e == 0) reset = 1'b1;
      data_in = stream[e];
      @(posedge clk_32f);
      #1;
      check("active", 32'(active), 32'(e_act[e]));
      check("strobe", 32'(byte_strobe), 32'(e_strb[e]));
      check("data",   32'(data_out), 32'(e_data[e]));
      check("valid",  32'(valid_out), 32'(e_valid[e]));
      check("lane",   32'(lane_out), 32'(e_lane[e]));
    end
    stream.delete();
  endtask

  initial begin
    bit [7:0] basic[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    reset   = 1'b0;
    data_in = 1'b0;

    // Basic sync.
    repeat (4) push_byte(COMMA);
    foreach (basic[i]) push_byte(basic[i]);
    push_rand_bits(3);
    run_segment();

    // Misaligned start.
    push_rand_bits(3);
    repeat (4) push_byte(COMMA);
    push_byte(8'hA5);
    push_rand_bits(2);
    run_segment();

    // Broken sync, then a clean comma run.
    repeat (3) push_byte(COMMA);
    push_byte(8'h00);
    repeat (4) push_byte(COMMA);
    push_byte(8'h7E);
    push_rand_bits(2);
    run_segment();

    // Idle byte embedded in the data stream.
    repeat (4) push_byte(COMMA);
    push_byte(8'h01);
    push_byte(COMMA);
    push_byte(8'h03);
    push_rand_bits(2);
    run_segment();

    // Sync, then stop 3 bits into a byte; the next segment resets mid-byte.
    repeat (4) push_byte(COMMA);
    push_byte(8'h42);
    push_rand_bits(3);
    run_segment();
    repeat (4) push_byte(COMMA);
    push_byte(8'h99);
    push_rand_bits(2);
    run_segment();

    // Random framing offsets, comma run lengths, breaks and payloads.
    for (int it = 0; it < 20; it++) begin
      push_rand_bits($urandom_range(0, 7));
      repeat ($urandom_range(2, 5)) push_byte(COMMA);
      if ($urandom_range(0, 1) == 1) begin
        push_byte(8'($urandom));
        repeat (4) push_byte(COMMA);
      end
      repeat ($urandom_range(1, 10)) begin
        if ($urandom_range(0, 5) == 0) push_byte(COMMA);
        else push_byte(8'($urandom));
      end
      push_rand_bits($urandom_range(2, 9));
      run_segment();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
